// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns and scan state type shared by the 7-segment driver
package seg7_pkg;
   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b0011111;
   localparam logic [6:0] SEG_C = 7'b1001110;
   localparam logic [6:0] SEG_D = 7'b0111101;
   localparam logic [6:0] SEG_E = 7'b1001111;
   localparam logic [6:0] SEG_F = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_TABLE [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                             SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
   typedef enum logic {DRIVE, BLANK} scan_state_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to segment pattern, dash for 10..15 outside hex mode
module seg7_hex_decode import seg7_pkg::*; (
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] seg
);
   assign seg = (!hex_mode && nibble > 4'd9) ? SEG_DASH : SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment scanner with per-frame shadowed inputs
module seg7_scan_driver import seg7_pkg::*; #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    hex_mode,
   input  logic                    lz_blank,
   input  logic                    enable,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_start
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
   localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   scan_state_t             state, state_d;
   logic [4*NUM_DIGITS-1:0] value_s;
   logic [NUM_DIGITS-1:0]   dp_s, onehot, dig_d;
   logic                    hex_s, lz_s, tick, wrap, lead_zero, blank, dp_sel, lit, seg_dp_d;
   logic [3:0]              nibble;
   logic [6:0]              dec, seg_d;

   assign tick      = presc == PW'(CLK_DIV - 1);
   assign wrap      = tick && idx == IW'(NUM_DIGITS - 1);
   assign nibble    = value_s[4*idx +: 4];
   assign lead_zero = (value_s >> (4*idx)) == '0;
   assign blank     = lz_s && idx != '0 && lead_zero;
   assign dp_sel    = dp_s[idx];
   assign onehot    = NUM_DIGITS'(1) << idx;

   seg7_hex_decode u_dec (
      .nibble   (nibble),
      .hex_mode (hex_s),
      .seg      (dec)
   );

   // prescaler, digit index and frame-coherent shadow capture on index wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= PW'(CLK_DIV - 1);
         idx     <= IW'(NUM_DIGITS - 1);
         value_s <= '0;
         dp_s    <= '0;
         hex_s   <= 1'b0;
         lz_s    <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) idx <= wrap ? '0 : idx + 1'b1;
         if (wrap) begin
            value_s <= value;
            dp_s    <= dp;
            hex_s   <= hex_mode;
            lz_s    <= lz_blank;
         end
      end
   end

   // next scan state and the output image for that state; outputs land with the state
   always_comb begin
      state_d  = (state == DRIVE && tick) ? BLANK : DRIVE;
      lit      = enable && state_d == DRIVE;
      seg_d    = ((lit && !blank) ? dec : SEG_BLANK) ^ SEG_OFF;
      seg_dp_d = (lit && dp_sel) ^ DP_OFF;
      dig_d    = ((lit && (!blank || dp_sel)) ? onehot : '0) ^ DIG_OFF;
   end

   // scan state and registered pin drivers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= DRIVE;
         seg         <= SEG_OFF;
         seg_dp      <= DP_OFF;
         dig_en      <= DIG_OFF;
         frame_start <= 1'b0;
      end else begin
         state       <= state_d;
         seg         <= seg_d;
         seg_dp      <= seg_dp_d;
         dig_en      <= dig_d;
         frame_start <= wrap;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: cycle-count reference model checks two driver configurations every cycle
module tb_seg7_scan_driver;
   typedef struct packed {
      logic       fs;
      logic       dp;
      logic [6:0] seg;
      logic [7:0] dig;
   } exp_t;

   localparam logic [6:0] TBL [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                       7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        hex_mode, lz_blank, enable;
   logic [6:0]  seg_a, seg_b;
   logic        seg_dp_a, seg_dp_b, fs_a, fs_b;
   logic [3:0]  dig_a;
   logic [2:0]  dig_b;

   int   total = 0;
   int   bad = 0;
   int   c = 0;
   bit   chk_on = 0;
   exp_t exp_a, exp_b;
   logic [15:0] sa_v;
   logic [11:0] sb_v;
   logic [3:0]  sa_dp;
   logic [2:0]  sb_dp;
   logic        sa_hx, sa_lz, sb_hx, sb_lz;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_a (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .hex_mode(hex_mode), .lz_blank(lz_blank),
      .enable(enable), .seg(seg_a), .seg_dp(seg_dp_a), .dig_en(dig_a), .frame_start(fs_a)
   );

   seg7_scan_driver #(.NUM_DIGITS(3), .CLK_DIV(5), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst(rst), .value(value[11:0]), .dp(dp[2:0]), .hex_mode(hex_mode), .lz_blank(lz_blank),
      .enable(enable), .seg(seg_b), .seg_dp(seg_dp_b), .dig_en(dig_b), .frame_start(fs_b)
   );

   // Output at cycle c+1 from the scan timeline: every d cycles a tick, slot m shows digit m%n,
   // first cycle after a tick is dark; frame captured at multiples of n*d.
   function automatic exp_t model(int n, int d, int cy, logic [31:0] sv, logic [7:0] sdp,
                                  logic shx, logic slz, logic en, bit al_s, bit al_d);
      exp_t e;
      int m, p, i;
      logic [3:0] nib;
      logic [6:0] pat;
      bit lit, blank;
      m = cy / d;
      p = cy % d;
      i = m % n;
      lit = (p != 0) && en;
      nib = sv[4*i +: 4];
      pat = (!shx && nib > 9) ? 7'b0000001 : TBL[nib];
      blank = slz && i > 0;
      for (int j = i; j < n; j++) if (sv[4*j +: 4] != 4'h0) blank = 0;
      e.fs  = (cy % (n*d)) == 0;
      e.seg = (lit && !blank) ? pat : 7'h00;
      e.dp  = lit && sdp[i];
      e.dig = (lit && (!blank || sdp[i])) ? 8'(1 << i) : 8'h00;
      if (al_s) begin
         e.seg = ~e.seg;
         e.dp  = ~e.dp;
      end
      if (al_d) e.dig = e.dig ^ 8'((1 << n) - 1);
      return e;
   endfunction

   function automatic exp_t idle(int n, bit al_s, bit al_d);
      exp_t e;
      e.fs  = 1'b0;
      e.seg = al_s ? 7'h7f : 7'h00;
      e.dp  = al_s;
      e.dig = al_d ? 8'((1 << n) - 1) : 8'h00;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s t=%0t cyc=%0d got=%b want=%b", nm, $time, c, act, want);
      end
   endtask

   task automatic at(input int k);
      int g = 0;
      while (c != k && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (c != k) begin
         total++;
         bad++;
         $display("FAIL at_timeout cyc=%0d want=%0d", c, k);
      end
   endtask

   // reference model: shadows and expected outputs advance on each clock edge
   always @(posedge clk) begin
      if (rst) begin
         c = 0;
         sa_v = '0; sa_dp = '0; sa_hx = 0; sa_lz = 0;
         sb_v = '0; sb_dp = '0; sb_hx = 0; sb_lz = 0;
         exp_a = idle(4, 0, 0);
         exp_b = idle(3, 1, 1);
         chk_on = 1;
      end else begin
         if (c % 16 == 0) begin
            sa_v = value; sa_dp = dp; sa_hx = hex_mode; sa_lz = lz_blank;
         end
         if (c % 15 == 0) begin
            sb_v = value[11:0]; sb_dp = dp[2:0]; sb_hx = hex_mode; sb_lz = lz_blank;
         end
         exp_a = model(4, 4, c, {16'h0, sa_v}, {4'h0, sa_dp}, sa_hx, sa_lz, enable, 0, 0);
         exp_b = model(3, 5, c, {20'h0, sb_v}, {5'h0, sb_dp}, sb_hx, sb_lz, enable, 1, 1);
         c++;
      end
   end

   // per-cycle comparison of both DUTs against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("a_seg", {1'b0, seg_a}, {1'b0, exp_a.seg});
         chk("a_dp", {7'h0, seg_dp_a}, {7'h0, exp_a.dp});
         chk("a_dig", {4'h0, dig_a}, exp_a.dig);
         chk("a_fs", {7'h0, fs_a}, {7'h0, exp_a.fs});
         chk("b_seg", {1'b0, seg_b}, {1'b0, exp_b.seg});
         chk("b_dp", {7'h0, seg_dp_b}, {7'h0, exp_b.dp});
         chk("b_dig", {5'h0, dig_b}, exp_b.dig);
         chk("b_fs", {7'h0, fs_b}, {7'h0, exp_b.fs});
      end
   end

   initial begin
      logic [15:0] v;
      value = 16'h1234; dp = 4'h0; hex_mode = 0; lz_blank = 0; enable = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      at(1);  chk("p_fs1", {7'h0, fs_a}, 8'd1);   chk("p_dig1", {4'h0, dig_a}, 8'h00);
      at(2);  chk("p_d0", {4'h0, dig_a}, 8'b0001); chk("p_s0", {1'b0, seg_a}, 8'b00110011);
              chk("p_b_s0", {1'b0, seg_b}, 8'b01001100); chk("p_b_d0", {5'h0, dig_b}, 8'b110);
      at(5);  chk("p_gap", {4'h0, dig_a}, 8'h00);
      at(6);  chk("p_d1", {4'h0, dig_a}, 8'b0010); chk("p_s1", {1'b0, seg_a}, 8'b01111001);
      at(7);  value = 16'h5678;
      at(10); chk("p_d2", {4'h0, dig_a}, 8'b0100); chk("p_s2", {1'b0, seg_a}, 8'b01101101);
      at(14); chk("p_d3", {4'h0, dig_a}, 8'b1000); chk("p_s3", {1'b0, seg_a}, 8'b00110000);
      at(17); chk("p_fs17", {7'h0, fs_a}, 8'd1);
      at(18); chk("p_new", {1'b0, seg_a}, 8'b01111111);
      at(20); value = 16'h0070; lz_blank = 1; dp = 4'b0100;
      at(34); chk("lz_d0", {1'b0, seg_a}, 8'b01111110);
      at(38); chk("lz_d1", {1'b0, seg_a}, 8'b01110000);
      at(42); chk("lz_d2dig", {4'h0, dig_a}, 8'b0100); chk("lz_d2seg", {1'b0, seg_a}, 8'h00);
              chk("lz_d2dp", {7'h0, seg_dp_a}, 8'd1);
      at(46); chk("lz_d3dig", {4'h0, dig_a}, 8'h00); chk("lz_d3dp", {7'h0, seg_dp_a}, 8'd0);
      at(50); value = 16'hABCF; hex_mode = 1; lz_blank = 0; dp = 4'h0;
      at(66); chk("hx_d0", {1'b0, seg_a}, 8'b01000111);
      at(70); chk("hx_d1", {1'b0, seg_a}, 8'b01001110);
      at(74); chk("hx_d2", {1'b0, seg_a}, 8'b00011111);
      at(78); chk("hx_d3", {1'b0, seg_a}, 8'b01110111);
      at(80); hex_mode = 0;
      at(98); chk("bcd_d0", {1'b0, seg_a}, 8'b00000001);
      at(110); chk("bcd_d3", {1'b0, seg_a}, 8'b00000001);
      at(112); value = 16'h0008; dp = 4'b0001;
      at(122); chk("al_seg", {1'b0, seg_b}, 8'h00); chk("al_dp", {7'h0, seg_dp_b}, 8'd0);
               chk("al_dig", {5'h0, dig_b}, 8'b110);
      at(126); chk("al_bseg", {1'b0, seg_b}, 8'h7f); chk("al_bdig", {5'h0, dig_b}, 8'b111);
      at(130); enable = 0;
      at(135); chk("en_dig", {4'h0, dig_a}, 8'h00); chk("en_seg", {1'b0, seg_a}, 8'h00);
      at(145); chk("en_fs", {7'h0, fs_a}, 8'd1);
      at(146); enable = 1;
      at(150); chk("en_back", {4'h0, dig_a}, 8'b0010); chk("en_bseg", {1'b0, seg_a}, 8'b01111110);
      at(161); chk("en_fs2", {7'h0, fs_a}, 8'd1);
      at(163); rst = 1;
      @(negedge clk);
      chk("rs_dig", {4'h0, dig_a}, 8'h00); chk("rs_seg", {1'b0, seg_a}, 8'h00);
      chk("rs_bdig", {5'h0, dig_b}, 8'b111);
      rst = 0;
      at(1);  chk("rs_dark", {4'h0, dig_a}, 8'h00);
      at(2);  chk("rs_d0", {4'h0, dig_a}, 8'b0001); chk("rs_s0", {1'b0, seg_a}, 8'b01111111);
              chk("rs_dp0", {7'h0, seg_dp_a}, 8'd1);
      for (int n = 0; n < 2500; n++) begin
         @(negedge clk);
         if ($urandom_range(7) == 0) begin
            for (int i = 0; i < 4; i++) v[4*i +: 4] = $urandom_range(1) ? 4'($urandom) : 4'h0;
            value = v;
         end
         if ($urandom_range(7) == 0) dp = 4'($urandom);
         if ($urandom_range(19) == 0) hex_mode = ~hex_mode;
         if ($urandom_range(19) == 0) lz_blank = ~lz_blank;
         enable = $urandom_range(15) != 0;
         rst = $urandom_range(399) == 0;
      end
      rst = 0;
      repeat (40) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
